// File: rtl/vga_pkg.sv
// vga_pkg: coordinate type and default 640x480@60 raster timing shared by the
// timing generator and its consumers.
package vga_pkg;
    typedef logic [9:0] coord_t;
    localparam int   H_VISIBLE_D   = 640;
    localparam int   H_FP_D        = 16;
    localparam int   H_SYNC_D      = 96;
    localparam int   H_BP_D        = 48;
    localparam int   V_VISIBLE_D   = 480;
    localparam int   V_FP_D        = 10;
    localparam int   V_SYNC_D      = 2;
    localparam int   V_BP_D        = 33;
    localparam int   CLK_DIV_D     = 2;
    localparam logic SYNC_ACTIVE_D = 1'b0;
endpackage

// File: rtl/vga_if.sv
// vga_if: raster counters plus VGA sync/blank/pixel-clock bundle; the timing
// generator drives it as master, renderers and the DAC side read it as slave.
interface vga_if;
    import vga_pkg::*;
    logic   pix_en;
    logic   vga_clk;
    coord_t cuentaX;
    coord_t cuentaY;
    logic   hsync;
    logic   vsync;
    logic   blank_n;
    logic   line_start;
    logic   frame_start;
    modport master (output pix_en, vga_clk, cuentaX, cuentaY, hsync, vsync, blank_n, line_start, frame_start);
    modport slave  (input  pix_en, vga_clk, cuentaX, cuentaY, hsync, vsync, blank_n, line_start, frame_start);
endinterface

// File: rtl/pixel_clk_div.sv
// pixel_clk_div: divides clk by CLK_DIV into a one-clk pixel strobe and a
// 50% duty pixel clock for the DAC.
module pixel_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic botonRST,
    output logic pix_en,
    output logic vga_clk
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] div_cnt_q, div_cnt_d;
    logic         pix_en_q, pix_en_d;
    logic         vga_clk_q, vga_clk_d;
    always_comb begin
        div_cnt_d = (div_cnt_q == W'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        pix_en_d  = div_cnt_q == W'(CLK_DIV - 1);
        vga_clk_d = div_cnt_q >= W'(CLK_DIV / 2);
    end
    always_ff @(posedge clk or negedge botonRST) begin
        if (!botonRST) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
            vga_clk_q <= vga_clk_d;
        end
    end
    assign pix_en  = pix_en_q;
    assign vga_clk = vga_clk_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster counters with sync and blank
// decoded from the next-state counters so they line up with cuentaX/cuentaY.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_D,
    parameter int   H_FP        = H_FP_D,
    parameter int   H_SYNC      = H_SYNC_D,
    parameter int   H_BP        = H_BP_D,
    parameter int   V_VISIBLE   = V_VISIBLE_D,
    parameter int   V_FP        = V_FP_D,
    parameter int   V_SYNC      = V_SYNC_D,
    parameter int   V_BP        = V_BP_D,
    parameter int   CLK_DIV     = CLK_DIV_D,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_D
) (
    input  logic  clk,
    input  logic  botonRST,
    vga_if.master vga
);
    localparam int     H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t X_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_LO   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_LO   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
    coord_t x_q, x_d, y_q, y_d;
    logic   hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic   x_wrap, y_wrap;
    pixel_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .botonRST (botonRST),
        .pix_en   (vga.pix_en),
        .vga_clk  (vga.vga_clk)
    );
    always_comb begin
        x_wrap        = x_q == X_LAST;
        y_wrap        = y_q == Y_LAST;
        x_d           = vga.pix_en ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d           = (vga.pix_en && x_wrap) ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
        hsync_d       = (x_d >= HS_LO && x_d < HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = (y_d >= VS_LO && y_d < VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        blank_n_d     = x_d < H_VIS && y_d < V_VIS;
        line_start_d  = vga.pix_en && x_wrap;
        frame_start_d = line_start_d && y_wrap;
    end
    always_ff @(posedge clk or negedge botonRST) begin
        if (!botonRST) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            blank_n_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end
    assign vga.cuentaX     = x_q;
    assign vga.cuentaY     = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_n_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance A and a small CLK_DIV=4,
// active-high-sync instance B, both checked every cycle against closed-form timing.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pix_en;
        logic       vga_clk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic ra = 1'b0;
    logic rb = 1'b0;
    int   na = 0;
    int   nb = 0;
    int   total_cnt = 0;
    int   pass_cnt = 0;
    obs_t oa, ob;

    vga_if ia();
    vga_if ib();

    vga_timing_gen dut_a (.clk(clk), .botonRST(ra), .vga(ia));
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4), .SYNC_ACTIVE(1'b1)
    ) dut_b (.clk(clk), .botonRST(rb), .vga(ib));

    assign oa = {ia.pix_en, ia.vga_clk, ia.cuentaX, ia.cuentaY, ia.hsync, ia.vsync, ia.blank_n, ia.line_start, ia.frame_start};
    assign ob = {ib.pix_en, ib.vga_clk, ib.cuentaX, ib.cuentaY, ib.hsync, ib.vsync, ib.blank_n, ib.line_start, ib.frame_start};

    always #5 clk = ~clk;

    // n = clk edges seen since reset release; everything observable follows from it
    always @(posedge clk) begin
        na = ra ? na + 1 : 0;
        nb = rb ? nb + 1 : 0;
    end

    function automatic obs_t model(input int n, d, hv, hf, hs, hb, vv, vf, vs, vb, input logic sa);
        obs_t o;
        int ht, p, x, y;
        ht = hv + hf + hs + hb;
        o = '0;
        o.hs = ~sa;
        o.vs = ~sa;
        if (n == 0) return o;
        p = ((n - 1) / d) % (ht * (vv + vf + vs + vb));
        x = p % ht;
        y = p / ht;
        o.pix_en  = (n % d) == 0;
        o.vga_clk = ((n - 1) % d) >= d / 2;
        o.x  = x[9:0];
        o.y  = y[9:0];
        o.hs = (x >= hv + hf && x < hv + hf + hs) ? sa : ~sa;
        o.vs = (y >= vv + vf && y < vv + vf + vs) ? sa : ~sa;
        o.bn = x < hv && y < vv;
        o.ls = n > d && (n - 1) % d == 0 && x == 0;
        o.fs = o.ls && y == 0;
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=0x%h required=0x%h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_a", 32'(oa), 32'(model(ra ? na : 0, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
        check("model_b", 32'(ob), 32'(model(rb ? nb : 0, 4, 16, 4, 6, 4, 12, 2, 2, 3, 1'b1)));
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input int x, input int y, input int lim, input string nm);
        int i = 0;
        while (!(ia.cuentaX == 10'(x) && ia.cuentaY == 10'(y)) && i < lim) begin
            step();
            i++;
        end
        check(nm, 32'(i < lim), 32'd1);
    endtask

    initial begin
        obs_t rst_a;
        int i, cnt, hs_cnt, vs_cnt, bl_cnt;
        rst_a = '{pix_en: 1'b0, vga_clk: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, bn: 1'b0, ls: 1'b0, fs: 1'b0};
        repeat (10) step();
        check("reset_a", 32'(oa), 32'(rst_a));
        check("reset_b_sync", {30'd0, ib.hsync, ib.vsync}, 32'd0);
        @(negedge clk);
        ra = 1'b1;
        rb = 1'b1;
        step();
        check("first_clk_bn_hs_vs", {29'd0, ia.blank_n, ia.hsync, ia.vsync}, 32'd7);
        check("first_clk_pix_en", {31'd0, ia.pix_en}, 32'd0);
        step();
        check("second_clk_pix_en", {31'd0, ia.pix_en}, 32'd1);
        step();
        check("x_after_first_adv", 32'(ia.cuentaX), 32'd1);
        repeat (2) step();
        check("x_after_second_adv", 32'(ia.cuentaX), 32'd2);
        wait_a(799, 10, 20000, "reach_799_10");
        i = 0;
        while (ia.cuentaX != 10'd0 && i < 4) begin
            step();
            i++;
        end
        check("line_wrap_xy", {ia.cuentaX, 6'd0, ia.cuentaY, 6'd0}, {10'd0, 6'd0, 10'd11, 6'd0});
        check("line_wrap_ls_fs", {30'd0, ia.line_start, ia.frame_start}, 32'd2);
        step();
        check("ls_one_clk", {31'd0, ia.line_start}, 32'd0);
        hs_cnt = 0;
        bl_cnt = 0;
        for (int k = 0; k < 1599; k++) begin
            hs_cnt += int'(!ia.hsync);
            bl_cnt += int'(!ia.blank_n);
            step();
        end
        hs_cnt += int'(!ia.hsync);
        bl_cnt += int'(!ia.blank_n);
        check("hsync_low_clks", 32'(hs_cnt), 32'd192);
        check("blank_low_clks", 32'(bl_cnt), 32'd320);
        wait_a(300, 12, 5000, "reach_300_12");
        @(posedge clk);
        #2 ra = 1'b0;
        #1 check("async_reset_a", 32'(oa), 32'(rst_a));
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #3 ra = 1'b1;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            cnt += int'(ia.frame_start);
        end
        check("no_fs_after_release", 32'(cnt), 32'd0);
        i = 0;
        while (!ib.frame_start && i < 3000) begin
            step();
            i++;
        end
        check("b_fs_found", 32'(i < 3000), 32'd1);
        check("b_fs_origin", {12'd0, ib.cuentaX, ib.cuentaY}, 32'd0);
        cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
        do begin
            step();
            cnt++;
            hs_cnt += int'(ib.hsync);
            vs_cnt += int'(ib.vsync);
        end while (!ib.frame_start && cnt < 5000);
        check("b_frame_period", 32'(cnt), 32'd2280);
        check("b_hsync_high_clks", 32'(hs_cnt), 32'd456);
        check("b_vsync_high_clks", 32'(vs_cnt), 32'd240);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(50, 2500)) @(posedge clk);
            #3;
            if ($urandom_range(0, 1) == 1) ra = 1'b0;
            else rb = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
            ra = 1'b1;
            rb = 1'b1;
        end
        repeat (200) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
